// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-field width and NOP encoding.
package mips_pipe_pkg;
  localparam int          REG_W     = 5;
  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the instruction in ID.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  output logic             load_use
);
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = idex_memread && (idex_rt != ZERO_REG) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and external freeze, zero-cycle output decode.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             branch_taken,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
`endif
);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam logic [1:0] STALL_NEXT   = (LOAD_STALL_CYCLES > 1) ? STALL : RUN;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use;

  load_use_detect u_lud (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .load_use     (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ext_stall) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            state_d = FLUSH_NEXT;
            cnt_d   = FLUSH_RELOAD;
          end else if (load_use) begin
            state_d = STALL_NEXT;
            cnt_d   = STALL_RELOAD;
          end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        end
        STALL: begin
          if (branch_taken) begin
            state_d = FLUSH_NEXT;
            cnt_d   = FLUSH_RELOAD;
          end else if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          // A new branch while squashing restarts the flush window.
          if (branch_taken) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst && !ext_stall) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
          end
          idex_bubble = 1'b1;
        end
        FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else if (!ext_stall) begin
      if (idex_bubble && !ifid_flush && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (ifid_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif
endmodule
